// File: rtl/tl_uncached_pkg.sv
// Shared TileLink uncached field widths, bit offsets and type codes used to pack and unpack
// acquire and grant beats.
package tl_uncached_pkg;

  localparam int unsigned ADDR_BLOCK_W = 26;
  localparam int unsigned XACT_ID_W    = 2;
  localparam int unsigned BEAT_W       = 3;
  localparam int unsigned UNION_W      = 12;
  localparam int unsigned DATA_W       = 64;
  localparam int unsigned ACQ_W        = 111;
  localparam int unsigned GNT_W        = 75;

  // Acquire: {addr_block, client_xact_id, addr_beat, is_builtin_type, a_type, union, data}
  localparam int unsigned ACQ_DATA_LSB    = 0;
  localparam int unsigned ACQ_UNION_LSB   = 64;
  localparam int unsigned ACQ_TYPE_LSB    = 76;
  localparam int unsigned ACQ_BUILTIN_BIT = 79;
  localparam int unsigned ACQ_BEAT_LSB    = 80;
  localparam int unsigned ACQ_ID_LSB      = 83;
  localparam int unsigned ACQ_ADDR_LSB    = 85;

  // Grant: {addr_beat, client_xact_id, manager_xact_id, is_builtin_type, g_type, data}
  localparam int unsigned GNT_DATA_LSB    = 0;
  localparam int unsigned GNT_TYPE_LSB    = 64;
  localparam int unsigned GNT_BUILTIN_BIT = 68;
  localparam int unsigned GNT_MGR_ID_BIT  = 69;
  localparam int unsigned GNT_ID_LSB      = 70;
  localparam int unsigned GNT_BEAT_LSB    = 72;

  typedef enum logic [2:0] {
    AcqGet       = 3'd0,
    AcqGetBlock  = 3'd1,
    AcqPut       = 3'd2,
    AcqPutBlock  = 3'd3,
    AcqPutAtomic = 3'd4
  } acq_type_e;

  typedef enum logic {
    StIdle,
    StLocked
  } arb_state_e;

  function automatic logic is_put_block(input logic builtin, input logic [2:0] a_type);
    return builtin && (a_type == AcqPutBlock);
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin picker: first valid entry searching from ptr upward, modulo N.
module tl_rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/tl_uncached_rr_arbiter.sv
// N-client uncached TileLink arbiter: round-robin acquire merge with PutBlock burst locking,
// source-tagged client_xact_id and tag-routed grant return.
module tl_uncached_rr_arbiter
  import tl_uncached_pkg::*;
#(
  parameter int unsigned N_CLIENTS = 2,
  parameter int unsigned BEATS     = 8,
  localparam int unsigned SRC_W    = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [N_CLIENTS-1:0]     io_in_acquire_ready,
  input  logic [N_CLIENTS-1:0]     io_in_acquire_valid,
  input  logic [N_CLIENTS*ACQ_W-1:0] io_in_acquire_bits,
  input  logic [N_CLIENTS-1:0]     io_in_grant_ready,
  output logic [N_CLIENTS-1:0]     io_in_grant_valid,
  output logic [GNT_W-1:0]         io_in_grant_bits,
  input  logic                     io_out_acquire_ready,
  output logic                     io_out_acquire_valid,
  output logic [ACQ_W+SRC_W-1:0]   io_out_acquire_bits,
  output logic                     io_out_grant_ready,
  input  logic                     io_out_grant_valid,
  input  logic [GNT_W+SRC_W-1:0]   io_out_grant_bits,
  output logic                     io_err_grant_src
);

  localparam int unsigned CNT_W = 4;

  arb_state_e       state_q;
  logic [SRC_W-1:0] rr_ptr_q;
  logic [SRC_W-1:0] lock_id_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             err_q;

  logic [ACQ_W-1:0]     acq [N_CLIENTS];
  logic [N_CLIENTS-1:0] pick_grant;
  logic [SRC_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [SRC_W-1:0]     winner;
  logic [ACQ_W-1:0]     sel;
  logic [N_CLIENTS-1:0] route;
  logic                 req_valid;
  logic                 is_head;
  logic                 acq_fire;
  logic [SRC_W-1:0]     src;
  logic                 src_ok;

  for (genvar g = 0; g < N_CLIENTS; g++) begin : gen_unpack
    assign acq[g] = io_in_acquire_bits[g*ACQ_W +: ACQ_W];
  end

  tl_rr_pick #(
    .N     (N_CLIENTS),
    .IDX_W (SRC_W)
  ) u_pick (
    .valid (io_in_acquire_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] i);
    return (32'(i) >= N_CLIENTS - 1) ? '0 : i + 1'b1;
  endfunction

  // Acquire path: locked bursts pin the winner, otherwise the picker chooses.
  always_comb begin
    route = '0;
    if (state_q == StLocked) begin
      winner    = lock_id_q;
      req_valid = io_in_acquire_valid[lock_id_q];
      for (int unsigned i = 0; i < N_CLIENTS; i++) begin
        route[i] = (lock_id_q == SRC_W'(i));
      end
    end else begin
      winner    = pick_idx;
      req_valid = pick_any;
      route     = pick_grant;
    end
    sel                  = acq[winner];
    io_out_acquire_valid = reset & req_valid;
    io_in_acquire_ready  = reset ? (route & {N_CLIENTS{io_out_acquire_ready}}) : '0;
    io_out_acquire_bits  = {sel[ACQ_W-1:ACQ_ID_LSB], winner, sel[ACQ_ID_LSB-1:0]};
    is_head   = (BEATS > 1) && is_put_block(sel[ACQ_BUILTIN_BIT], sel[ACQ_TYPE_LSB +: 3]);
    acq_fire  = io_out_acquire_valid & io_out_acquire_ready;
  end

  // Grant path: stateless, routed purely by the source tag; illegal tags are sunk.
  always_comb begin
    src    = io_out_grant_bits[GNT_ID_LSB +: SRC_W];
    src_ok = 32'(src) < N_CLIENTS;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      io_in_grant_valid[i] = reset & io_out_grant_valid & src_ok & (src == SRC_W'(i));
    end
    io_out_grant_ready = reset & (src_ok ? io_in_grant_ready[src] : 1'b1);
    io_in_grant_bits   = {io_out_grant_bits[GNT_W+SRC_W-1:GNT_ID_LSB+SRC_W],
                          io_out_grant_bits[GNT_ID_LSB-1:0]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (acq_fire) begin
        case (state_q)
          StIdle: begin
            if (is_head) begin
              state_q    <= StLocked;
              lock_id_q  <= winner;
              beat_cnt_q <= CNT_W'(1);
            end else begin
              rr_ptr_q <= rr_next(winner);
            end
          end
          StLocked: begin
            if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
              state_q    <= StIdle;
              beat_cnt_q <= '0;
              rr_ptr_q   <= rr_next(lock_id_q);
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
      if (io_out_grant_valid && !src_ok) err_q <= 1'b1;
    end
  end

  assign io_err_grant_src = err_q;

endmodule

// File: tb/tb_tl_uncached_rr_arbiter.sv
// Scoreboard bench for tl_uncached_rr_arbiter: a 2-client instance for arbitration, locking and
// grant routing, plus a 3-client instance for illegal grant sources.
module tb_tl_uncached_rr_arbiter;
  import tl_uncached_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 2-client instance
  logic [1:0]   a_rdy2, a_vld2, g_rdy2, g_vld2;
  logic [221:0] a_bits2;
  logic [74:0]  g_bits2;
  logic         o_a_rdy2, o_a_vld2, o_g_rdy2, o_g_vld2, err2;
  logic [111:0] o_a_bits2;
  logic [75:0]  o_g_bits2;

  // 3-client instance
  logic [2:0]   a_rdy3, a_vld3, g_rdy3, g_vld3;
  logic [332:0] a_bits3;
  logic [74:0]  g_bits3;
  logic         o_a_rdy3, o_a_vld3, o_g_rdy3, o_g_vld3, err3;
  logic [112:0] o_a_bits3;
  logic [76:0]  o_g_bits3;

  int n_vec = 0;
  int n_err = 0;
  logic [111:0] exp_q[$];
  logic [111:0] exp_v;

  tl_uncached_rr_arbiter #(.N_CLIENTS(2), .BEATS(8)) dut2 (
    .clk                  (clk),
    .reset                (rst),
    .io_in_acquire_ready  (a_rdy2),
    .io_in_acquire_valid  (a_vld2),
    .io_in_acquire_bits   (a_bits2),
    .io_in_grant_ready    (g_rdy2),
    .io_in_grant_valid    (g_vld2),
    .io_in_grant_bits     (g_bits2),
    .io_out_acquire_ready (o_a_rdy2),
    .io_out_acquire_valid (o_a_vld2),
    .io_out_acquire_bits  (o_a_bits2),
    .io_out_grant_ready   (o_g_rdy2),
    .io_out_grant_valid   (o_g_vld2),
    .io_out_grant_bits    (o_g_bits2),
    .io_err_grant_src     (err2)
  );

  tl_uncached_rr_arbiter #(.N_CLIENTS(3), .BEATS(8)) dut3 (
    .clk                  (clk),
    .reset                (rst),
    .io_in_acquire_ready  (a_rdy3),
    .io_in_acquire_valid  (a_vld3),
    .io_in_acquire_bits   (a_bits3),
    .io_in_grant_ready    (g_rdy3),
    .io_in_grant_valid    (g_vld3),
    .io_in_grant_bits     (g_bits3),
    .io_out_acquire_ready (o_a_rdy3),
    .io_out_acquire_valid (o_a_vld3),
    .io_out_acquire_bits  (o_a_bits3),
    .io_out_grant_ready   (o_g_rdy3),
    .io_out_grant_valid   (o_g_vld3),
    .io_out_grant_bits    (o_g_bits3),
    .io_err_grant_src     (err3)
  );

  // Client c's beat as presented on its input port.
  function automatic logic [110:0] acq_in(int c, int beat, bit pb);
    return {26'(32'h0ABC00 + c), 2'(c + 2), 3'(beat), 1'b1, pb ? 3'd3 : 3'd0, 12'hA5C,
            32'(32'hDA7A0000 | c), 32'(beat)};
  endfunction

  // The same beat as the manager must see it, with the 1-bit source tag under the id.
  function automatic logic [111:0] acq_out(int c, int beat, bit pb);
    return {26'(32'h0ABC00 + c), 2'(c + 2), 1'(c), 3'(beat), 1'b1, pb ? 3'd3 : 3'd0, 12'hA5C,
            32'(32'hDA7A0000 | c), 32'(beat)};
  endfunction

  task automatic set_acq2(int c, int beat, bit pb);
    a_bits2[c*ACQ_W +: ACQ_W] = acq_in(c, beat, pb);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_vld2 = 2'b11; set_acq2(0, 0, 0); set_acq2(1, 0, 0); o_a_rdy2 = 1'b1;
    o_g_vld2 = 1'b1; o_g_bits2 = '0; g_rdy2 = 2'b11;
    a_vld3 = 3'b111; o_a_rdy3 = 1'b1; o_g_vld3 = 1'b1;
    o_g_bits3 = {3'd0, 2'b00, 2'd3, 70'd0}; g_rdy3 = 3'b111;
    cycle(); cycle();
    n_vec++; if (o_a_vld2 !== 1'b0) begin n_err++; $display("FAIL rst_out_valid2: got %b want 0", o_a_vld2); end
    n_vec++; if (a_rdy2 !== 2'b00) begin n_err++; $display("FAIL rst_in_ready2: got %b want 00", a_rdy2); end
    n_vec++; if (g_vld2 !== 2'b00) begin n_err++; $display("FAIL rst_grant_valid2: got %b want 00", g_vld2); end
    n_vec++; if (o_g_rdy2 !== 1'b0) begin n_err++; $display("FAIL rst_grant_ready2: got %b want 0", o_g_rdy2); end
    n_vec++; if (o_a_vld3 !== 1'b0 || a_rdy3 !== 3'b000) begin
      n_err++; $display("FAIL rst_acq3: got vld %b rdy %b want 0 000", o_a_vld3, a_rdy3);
    end
    n_vec++; if (o_g_rdy3 !== 1'b0) begin n_err++; $display("FAIL rst_grant_ready3: got %b want 0", o_g_rdy3); end
    n_vec++; if (err2 !== 1'b0 || err3 !== 1'b0) begin
      n_err++; $display("FAIL rst_err: got %b %b want 0 0", err2, err3);
    end
    a_vld2 = 2'b00; o_g_vld2 = 1'b0; a_vld3 = 3'b000; o_g_vld3 = 1'b0; rst = 1'b1;
    cycle();
  endtask

  task automatic test_round_robin();
    a_vld2 = 2'b11; set_acq2(0, 0, 0); set_acq2(1, 0, 0); o_a_rdy2 = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back(acq_out(k % 2, 0, 0));
    for (int k = 0; k < 6; k++) begin
      #1;
      n_vec++; if (a_rdy2 !== 2'(1 << (k % 2))) begin
        n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", k, a_rdy2, 2'(1 << (k % 2)));
      end
      n_vec++;
      if (!(o_a_vld2 && o_a_rdy2) || exp_q.size() == 0) begin
        n_err++; $display("FAIL rr_handshake[%0d]: got vld %b want 1", k, o_a_vld2);
      end else begin
        exp_v = exp_q.pop_front();
        if (o_a_bits2 !== exp_v) begin n_err++; $display("FAIL rr_bits[%0d]: got %h want %h", k, o_a_bits2, exp_v); end
      end
      cycle();
    end
    a_vld2 = 2'b00;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_left: got %0d want 0", exp_q.size()); end
    exp_q.delete();
    cycle();
  endtask

  task automatic test_burst();
    logic [1:0] er;
    a_vld2 = 2'b11; set_acq2(1, 0, 0); o_a_rdy2 = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(acq_out(0, k, 1));
    exp_q.push_back(acq_out(1, 0, 0));
    for (int k = 0; k < 9; k++) begin
      if (k < 8) set_acq2(0, k, 1); else set_acq2(0, 0, 0);
      #1;
      er = (k < 8) ? 2'b01 : 2'b10;
      n_vec++; if (a_rdy2 !== er) begin n_err++; $display("FAIL burst_ready[%0d]: got %b want %b", k, a_rdy2, er); end
      n_vec++;
      if (!(o_a_vld2 && o_a_rdy2) || exp_q.size() == 0) begin
        n_err++; $display("FAIL burst_handshake[%0d]: got vld %b want 1", k, o_a_vld2);
      end else begin
        exp_v = exp_q.pop_front();
        if (o_a_bits2 !== exp_v) begin n_err++; $display("FAIL burst_bits[%0d]: got %h want %h", k, o_a_bits2, exp_v); end
      end
      cycle();
    end
    a_vld2 = 2'b00;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL burst_left: got %0d want 0", exp_q.size()); end
    exp_q.delete();
    cycle();
  endtask

  task automatic test_stall();
    int b;
    logic [1:0] er;
    a_vld2 = 2'b11; set_acq2(1, 0, 0);
    for (int k = 0; k < 8; k++) exp_q.push_back(acq_out(0, k, 1));
    exp_q.push_back(acq_out(1, 0, 0));
    for (int c = 0; c < 12; c++) begin
      b = (c < 4) ? c : ((c < 7) ? 4 : c - 3);
      if (c < 11) set_acq2(0, b, 1); else set_acq2(0, 0, 0);
      o_a_rdy2 = !(c >= 4 && c < 7);
      #1;
      if (!o_a_rdy2) begin
        n_vec++; if (o_a_vld2 !== 1'b1 || a_rdy2 !== 2'b00 || o_a_bits2 !== acq_out(0, 4, 1)) begin
          n_err++; $display("FAIL stall_hold[%0d]: got vld %b rdy %b bits %h want 1 00 %h",
                            c, o_a_vld2, a_rdy2, o_a_bits2, acq_out(0, 4, 1));
        end
      end else begin
        er = (c < 11) ? 2'b01 : 2'b10;
        n_vec++; if (a_rdy2 !== er) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want %b", c, a_rdy2, er); end
        n_vec++;
        if (!(o_a_vld2 && o_a_rdy2) || exp_q.size() == 0) begin
          n_err++; $display("FAIL stall_handshake[%0d]: got vld %b want 1", c, o_a_vld2);
        end else begin
          exp_v = exp_q.pop_front();
          if (o_a_bits2 !== exp_v) begin n_err++; $display("FAIL stall_bits[%0d]: got %h want %h", c, o_a_bits2, exp_v); end
        end
      end
      cycle();
    end
    a_vld2 = 2'b00; o_a_rdy2 = 1'b1;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_left: got %0d want 0", exp_q.size()); end
    exp_q.delete();
    cycle();
  endtask

  task automatic test_grant();
    // Acquire from client0 in the same cycle as a grant to client1.
    a_vld2 = 2'b01; set_acq2(0, 0, 0); o_a_rdy2 = 1'b1;
    exp_q.push_back(acq_out(0, 0, 0));
    o_g_vld2 = 1'b1; g_rdy2 = 2'b01;
    o_g_bits2 = {3'd5, 2'b10, 1'b1, 1'b1, 1'b1, 4'd5, 64'hFEED_F00D_1234_5678};
    #1;
    n_vec++; if (g_vld2 !== 2'b10) begin n_err++; $display("FAIL gnt_valid_src1: got %b want 10", g_vld2); end
    n_vec++; if (g_bits2 !== {3'd5, 2'b10, 1'b1, 1'b1, 4'd5, 64'hFEED_F00D_1234_5678}) begin
      n_err++; $display("FAIL gnt_bits_src1: got %h want %h", g_bits2,
                        {3'd5, 2'b10, 1'b1, 1'b1, 4'd5, 64'hFEED_F00D_1234_5678});
    end
    n_vec++; if (o_g_rdy2 !== 1'b0) begin n_err++; $display("FAIL gnt_backpressure: got %b want 0", o_g_rdy2); end
    n_vec++;
    if (!(o_a_vld2 && o_a_rdy2) || exp_q.size() == 0) begin
      n_err++; $display("FAIL gnt_acq_handshake: got vld %b want 1", o_a_vld2);
    end else begin
      exp_v = exp_q.pop_front();
      if (o_a_bits2 !== exp_v) begin n_err++; $display("FAIL gnt_acq_bits: got %h want %h", o_a_bits2, exp_v); end
    end
    cycle();
    a_vld2 = 2'b00;
    g_rdy2 = 2'b10;
    #1;
    n_vec++; if (o_g_rdy2 !== 1'b1) begin n_err++; $display("FAIL gnt_ready_src1: got %b want 1", o_g_rdy2); end
    o_g_bits2 = {3'd2, 2'b01, 1'b0, 1'b0, 1'b1, 4'd4, 64'h0123_4567_89AB_CDEF};
    #1;
    n_vec++; if (g_vld2 !== 2'b01 || o_g_rdy2 !== 1'b0) begin
      n_err++; $display("FAIL gnt_src0: got vld %b rdy %b want 01 0", g_vld2, o_g_rdy2);
    end
    n_vec++; if (g_bits2 !== {3'd2, 2'b01, 1'b0, 1'b1, 4'd4, 64'h0123_4567_89AB_CDEF}) begin
      n_err++; $display("FAIL gnt_bits_src0: got %h want %h", g_bits2,
                        {3'd2, 2'b01, 1'b0, 1'b1, 4'd4, 64'h0123_4567_89AB_CDEF});
    end
    o_g_vld2 = 1'b0;
    #1;
    n_vec++; if (g_vld2 !== 2'b00 || err2 !== 1'b0) begin
      n_err++; $display("FAIL gnt_idle: got vld %b err %b want 00 0", g_vld2, err2);
    end
    exp_q.delete();
    cycle();
  endtask

  task automatic test_err_src();
    o_g_vld3 = 1'b1; g_rdy3 = 3'b000;
    o_g_bits3 = {3'd1, 2'b11, 2'd3, 1'b0, 1'b1, 4'd0, 64'h0BAD};
    #1;
    n_vec++; if (o_g_rdy3 !== 1'b1 || g_vld3 !== 3'b000) begin
      n_err++; $display("FAIL err_drop: got rdy %b vld %b want 1 000", o_g_rdy3, g_vld3);
    end
    n_vec++; if (err3 !== 1'b0) begin n_err++; $display("FAIL err_early: got %b want 0", err3); end
    cycle();
    o_g_vld3 = 1'b0;
    #1;
    n_vec++; if (err3 !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", err3); end
    o_g_vld3 = 1'b1; g_rdy3 = 3'b100;
    o_g_bits3 = {3'd1, 2'b00, 2'd2, 1'b0, 1'b1, 4'd0, 64'h0BAD};
    #1;
    n_vec++; if (g_vld3 !== 3'b100 || o_g_rdy3 !== 1'b1) begin
      n_err++; $display("FAIL err_legal_src2: got vld %b rdy %b want 100 1", g_vld3, o_g_rdy3);
    end
    n_vec++; if (g_bits3 !== {3'd1, 2'b00, 1'b0, 1'b1, 4'd0, 64'h0BAD}) begin
      n_err++; $display("FAIL err_legal_bits: got %h want %h", g_bits3, {3'd1, 2'b00, 1'b0, 1'b1, 4'd0, 64'h0BAD});
    end
    cycle();
    o_g_vld3 = 1'b0;
    cycle(); cycle(); cycle();
    n_vec++; if (err3 !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err3); end
  endtask

  task automatic test_reset_mid_burst();
    // Client0 alone, so it wins from rr_ptr=1 left by the previous test.
    a_vld2 = 2'b01; o_a_rdy2 = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back(acq_out(0, k, 1));
    for (int k = 0; k < 5; k++) begin
      set_acq2(0, k, 1);
      #1;
      n_vec++;
      if (!(o_a_vld2 && o_a_rdy2) || exp_q.size() == 0) begin
        n_err++; $display("FAIL mid_handshake[%0d]: got vld %b want 1", k, o_a_vld2);
      end else begin
        exp_v = exp_q.pop_front();
        if (o_a_bits2 !== exp_v) begin n_err++; $display("FAIL mid_bits[%0d]: got %h want %h", k, o_a_bits2, exp_v); end
      end
      cycle();
    end
    set_acq2(0, 5, 1); rst = 1'b0;
    o_g_vld2 = 1'b1; o_g_bits2 = {3'd0, 2'b00, 1'b1, 70'd0}; g_rdy2 = 2'b11;
    #1;
    n_vec++; if (o_a_vld2 !== 1'b0 || a_rdy2 !== 2'b00 || g_vld2 !== 2'b00 || o_g_rdy2 !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_outputs: got %b %b %b %b want 0 00 00 0", o_a_vld2, a_rdy2, g_vld2, o_g_rdy2);
    end
    cycle();
    rst = 1'b1; o_g_vld2 = 1'b0;
    a_vld2 = 2'b11; set_acq2(0, 0, 0); set_acq2(1, 0, 0);
    exp_q.push_back(acq_out(0, 0, 0));
    #1;
    n_vec++; if (err3 !== 1'b0) begin n_err++; $display("FAIL mid_err_cleared: got %b want 0", err3); end
    n_vec++; if (a_rdy2 !== 2'b01) begin n_err++; $display("FAIL mid_ptr_reset: got %b want 01", a_rdy2); end
    n_vec++;
    if (!(o_a_vld2 && o_a_rdy2) || exp_q.size() == 0) begin
      n_err++; $display("FAIL mid_post0: got vld %b want 1", o_a_vld2);
    end else begin
      exp_v = exp_q.pop_front();
      if (o_a_bits2 !== exp_v) begin n_err++; $display("FAIL mid_post0_bits: got %h want %h", o_a_bits2, exp_v); end
    end
    cycle();
    a_vld2 = 2'b10;
    exp_q.push_back(acq_out(1, 0, 0));
    #1;
    n_vec++; if (a_rdy2 !== 2'b10) begin n_err++; $display("FAIL mid_lock_dropped: got %b want 10", a_rdy2); end
    n_vec++;
    if (!(o_a_vld2 && o_a_rdy2) || exp_q.size() == 0) begin
      n_err++; $display("FAIL mid_post1: got vld %b want 1", o_a_vld2);
    end else begin
      exp_v = exp_q.pop_front();
      if (o_a_bits2 !== exp_v) begin n_err++; $display("FAIL mid_post1_bits: got %h want %h", o_a_bits2, exp_v); end
    end
    cycle();
    a_vld2 = 2'b00;
    exp_q.delete();
    cycle();
  endtask

  initial begin
    a_vld2 = '0; a_bits2 = '0; g_rdy2 = '0; o_a_rdy2 = 1'b0; o_g_vld2 = 1'b0; o_g_bits2 = '0;
    a_vld3 = '0; a_bits3 = '0; g_rdy3 = '0; o_a_rdy3 = 1'b0; o_g_vld3 = 1'b0; o_g_bits3 = '0;
    cycle();
    test_reset();
    test_round_robin();
    test_burst();
    test_stall();
    test_grant();
    test_err_src();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
